// File: rtl/vxc_add_sequencer_pkg.sv
// Shared types and defaults for the vXc-add block sequencer.
// Holds the FSM encoding, the latched job record and the block-count helper.
package vxc_add_sequencer_pkg;

   localparam int EW_DEF      = 64;
   localparam int NI_DEF      = 8;
   localparam int AW_DEF      = 16;
   localparam int TIMEOUT_DEF = 1024;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_WAIT_RD = 3'd2,
      ST_ISSUE   = 3'd3,
      ST_WAIT_DP = 3'd4,
      ST_WRITE   = 3'd5
   } state_t;

   typedef struct packed {
      logic [31:0] total;
      logic        op;
   } job_t;

   // Index of the final block, ceil(total / 2^lg) - 1, computed at 33 bits so total near 2^32 cannot overflow.
   function automatic logic [31:0] last_blk_index(input logic [31:0] total, input int lg);
      logic [32:0] nblk;
      nblk = ({1'b0, total} + ((33'd1 << lg) - 33'd1)) >> lg;
      return 32'(nblk - 33'd1);
   endfunction

endpackage

// File: rtl/vxc_add_sequencer_if.sv
// Job, operand-memory, datapath and result-memory signals of the sequencer.
// master = sequencer side, slave = surrounding memories, datapath and job source.
interface vxc_add_sequencer_if #(
   parameter int EW = 64,
   parameter int NI = 8,
   parameter int AW = 16
);
   logic               start;
   logic [31:0]        total;
   logic               op;
   logic [EW-1:0]      constant;

   logic               read_again;
   logic [AW-1:0]      rd_addr;
   logic               rd_valid;
   logic [EW*NI-1:0]   first_row_fixed;
   logic [EW*NI-1:0]   second_row_fixed;

   logic [EW*NI-1:0]   dp_first_row;
   logic [EW*NI-1:0]   dp_second_row;
   logic [EW-1:0]      dp_constant;
   logic               dp_op;
   logic               dp_start;
   logic               dp_done;
   logic [EW*NI-1:0]   dp_result;

   logic               result_mem_we;
   logic [AW-1:0]      result_addr;
   logic [EW*NI-1:0]   result_data;
   logic [NI-1:0]      lane_mask;
   logic               busy;
   logic               finish;
   logic               error;

   modport master (
      input  start, total, op, constant, rd_valid, first_row_fixed, second_row_fixed,
             dp_done, dp_result,
      output read_again, rd_addr, dp_first_row, dp_second_row, dp_constant, dp_op, dp_start,
             result_mem_we, result_addr, result_data, lane_mask, busy, finish, error
   );

   modport slave (
      output start, total, op, constant, rd_valid, first_row_fixed, second_row_fixed,
             dp_done, dp_result,
      input  read_again, rd_addr, dp_first_row, dp_second_row, dp_constant, dp_op, dp_start,
             result_mem_we, result_addr, result_data, lane_mask, busy, finish, error
   );
endinterface

// File: rtl/vxc_blk_addr_gen.sv
// Block counter with last-block detect and lane mask for the partial tail block.
// Counter updates one cycle after clr/inc; last/lane_mask are combinational.
// No backpressure: the sequencer FSM decides when to clear or advance.
module vxc_blk_addr_gen
   import vxc_add_sequencer_pkg::*;
#(
   parameter int NI = NI_DEF,
   parameter int AW = AW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          inc,
   input  logic [31:0]   total,
   output logic [AW-1:0] blk,
   output logic          last,
   output logic [NI-1:0] lane_mask
);
   localparam int LG = $clog2(NI);

   logic [LG-1:0] rem;
   logic [AW-1:0] last_idx;

   assign rem      = total[LG-1:0];
   assign last_idx = AW'(last_blk_index(total, LG));
   assign last     = (blk == last_idx);

   always_comb begin
      lane_mask = '1;
      if (last && rem != '0)
         lane_mask = (NI'(1) << rem) - NI'(1);
   end

   always_ff @(posedge clk) begin
      if (reset || clr)
         blk <= '0;
      else if (inc)
         blk <= blk + AW'(1);
   end
endmodule

// File: rtl/vxc_add_sequencer.sv
// Walks a complex vector in NI-lane blocks through the vXc-add datapath, one block in flight.
// Per block: FETCH, WAIT_RD, ISSUE, WAIT_DP (L cycles), WRITE = L+4 cycles with 1-cycle reads.
// Stalls in WAIT_RD until rd_valid and in WAIT_DP until dp_done; aborts after TIMEOUT cycles of WAIT_DP.
module vxc_add_sequencer
   import vxc_add_sequencer_pkg::*;
#(
   parameter int element_width = EW_DEF,
   parameter int no_of_units   = NI_DEF,
   parameter int AW            = AW_DEF,
   parameter int TIMEOUT       = TIMEOUT_DEF
) (
   input logic                 clk,
   input logic                 reset,
   vxc_add_sequencer_if.master bus
);
   localparam int RW = element_width * no_of_units;
   localparam int CW = $clog2(TIMEOUT + 1);

   state_t                   state, state_nxt;
   job_t                     job;
   logic [element_width-1:0] const_q;
   logic [RW-1:0]            row_a_q, row_b_q, result_q;
   logic                     finish_q, error_q;
   logic [CW-1:0]            tmo_cnt;
   logic                     blk_clr, blk_inc, last_blk, timed_out, accept;
   logic [AW-1:0]            blk;
   logic [no_of_units-1:0]   blk_mask;

   assign accept    = (state == ST_IDLE) && bus.start;
   assign timed_out = (state == ST_WAIT_DP) && !bus.dp_done && (tmo_cnt == CW'(TIMEOUT - 1));

   vxc_blk_addr_gen #(.NI(no_of_units), .AW(AW)) u_addr (
      .clk       (clk),
      .reset     (reset),
      .clr       (blk_clr),
      .inc       (blk_inc),
      .total     (job.total),
      .blk       (blk),
      .last      (last_blk),
      .lane_mask (blk_mask)
   );

   always_comb begin
      state_nxt = state;
      blk_clr   = 1'b0;
      blk_inc   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               blk_clr = 1'b1;
               // An empty job completes from IDLE without touching either memory.
               if (bus.total != 32'd0)
                  state_nxt = ST_FETCH;
            end
         end
         ST_FETCH:   state_nxt = ST_WAIT_RD;
         ST_WAIT_RD: if (bus.rd_valid) state_nxt = ST_ISSUE;
         ST_ISSUE:   state_nxt = ST_WAIT_DP;
         ST_WAIT_DP: begin
            if (bus.dp_done)
               state_nxt = ST_WRITE;
            else if (timed_out)
               state_nxt = ST_IDLE;
         end
         ST_WRITE: begin
            if (last_blk) begin
               state_nxt = ST_IDLE;
            end else begin
               blk_inc   = 1'b1;
               state_nxt = ST_FETCH;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         job      <= '0;
         const_q  <= '0;
         row_a_q  <= '0;
         row_b_q  <= '0;
         result_q <= '0;
         finish_q <= 1'b0;
         error_q  <= 1'b0;
         tmo_cnt  <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            job.total <= bus.total;
            job.op    <= bus.op;
            const_q   <= bus.constant;
            finish_q  <= (bus.total == 32'd0);
            error_q   <= 1'b0;
         end
         if (state == ST_WAIT_RD && bus.rd_valid) begin
            row_a_q <= bus.first_row_fixed;
            row_b_q <= bus.second_row_fixed;
         end
         if (state == ST_WAIT_DP && bus.dp_done)
            result_q <= bus.dp_result;
         tmo_cnt <= (state == ST_WAIT_DP) ? tmo_cnt + CW'(1) : '0;
         if (timed_out) begin
            error_q  <= 1'b1;
            finish_q <= 1'b1;
         end
         if (state == ST_WRITE && last_blk)
            finish_q <= 1'b1;
      end
   end

   assign bus.read_again    = (state == ST_FETCH);
   assign bus.rd_addr       = blk;
   assign bus.dp_first_row  = row_a_q;
   assign bus.dp_second_row = row_b_q;
   assign bus.dp_constant   = const_q;
   assign bus.dp_op         = job.op;
   assign bus.dp_start      = (state == ST_ISSUE);
   assign bus.result_mem_we = (state == ST_WRITE);
   assign bus.result_addr   = blk;
   assign bus.result_data   = result_q;
   assign bus.busy          = (state != ST_IDLE);
   assign bus.lane_mask     = (state != ST_IDLE) ? blk_mask : '0;
   assign bus.finish        = finish_q;
   assign bus.error         = error_q;
endmodule

// File: tb/tb_vxc_add_sequencer.sv
// Directed bench for vxc_add_sequencer: operand-memory and datapath responders plus a strobe monitor,
// driven by one linear sequence of job steps with hand-derived expectations.
module tb_vxc_add_sequencer;
   localparam int EW   = 64;
   localparam int NI   = 8;
   localparam int AW   = 16;
   localparam int TMO  = 16;
   localparam int DP_L = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   vxc_add_sequencer_if #(.EW(EW), .NI(NI), .AW(AW)) bus ();

   vxc_add_sequencer #(
      .element_width (EW),
      .no_of_units   (NI),
      .AW            (AW),
      .TIMEOUT       (TMO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_tot = 0;
   int n_bad = 0;
   int cyc = 0;
   int n_ra = 0, n_ds = 0, n_we = 0, ds_cyc = 0;
   logic [15:0]  wr_addr[$];
   logic [511:0] wr_data[$];
   logic [7:0]   wr_mask[$];
   int           wr_cyc[$];

   bit          rd_pend = 0, dp_pend = 0;
   int          rd_cnt = 0, dp_cnt = 0;
   logic [15:0] rd_a = '0;
   bit          rd_rand = 0;
   int          rd_dly = 0;
   bit          dp_en = 1;
   bit          stray_dp = 0;

   task automatic chk(input string tag, input logic [511:0] o, input logic [511:0] e);
      n_tot++;
      if (o !== e) begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   function automatic logic [511:0] row_a(input int b);
      logic [511:0] r;
      for (int i = 0; i < NI; i++)
         r[i*64 +: 64] = {32'(b*16 + i + 1), 32'hA000_0000 + 32'(b*8 + i)};
      return r;
   endfunction

   function automatic logic [511:0] row_b(input int b);
      logic [511:0] r;
      for (int i = 0; i < NI; i++)
         r[i*64 +: 64] = {32'(b*3 + i*5 + 7), 32'h1234_0000 ^ 32'(b*16 + i)};
      return r;
   endfunction

   // Stand-in for the datapath: per lane re = a.re+b.re+c.re, im = a.im +/- (b.im+c.im).
   function automatic logic [511:0] dp_f(input logic [511:0] a, input logic [511:0] b,
                                         input logic [63:0] c, input logic op);
      logic [511:0] r;
      logic [31:0]  re, im;
      for (int i = 0; i < NI; i++) begin
         re = a[i*64+32 +: 32] + b[i*64+32 +: 32] + c[63:32];
         im = op ? (a[i*64 +: 32] - b[i*64 +: 32] - c[31:0])
                 : (a[i*64 +: 32] + b[i*64 +: 32] + c[31:0]);
         r[i*64 +: 64] = {re, im};
      end
      return r;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Operand memory and datapath responders; rows carry junk except on the rd_valid cycle.
   always @(negedge clk) begin
      bus.rd_valid         = 1'b0;
      bus.first_row_fixed  = {16{32'hDEAD_BEEF}};
      bus.second_row_fixed = {16{32'hBAD0_CAFE}};
      bus.dp_done          = stray_dp;
      bus.dp_result        = {16{32'h5A5A_A5A5}};
      if (reset) begin
         rd_pend = 0;
         dp_pend = 0;
      end else begin
         if (rd_pend) begin
            if (rd_cnt == 0) begin
               bus.rd_valid         = 1'b1;
               bus.first_row_fixed  = row_a(int'(rd_a));
               bus.second_row_fixed = row_b(int'(rd_a));
               rd_pend = 0;
            end else begin
               rd_cnt--;
            end
         end
         if (bus.read_again) begin
            rd_pend = 1;
            rd_a    = bus.rd_addr;
            rd_cnt  = rd_rand ? int'($urandom_range(0, 5)) : rd_dly;
         end
         if (dp_pend) begin
            if (dp_cnt == 0) begin
               bus.dp_done   = 1'b1;
               bus.dp_result = dp_f(bus.dp_first_row, bus.dp_second_row, bus.dp_constant, bus.dp_op);
               dp_pend = 0;
            end else begin
               dp_cnt--;
            end
         end
         if (bus.dp_start && dp_en) begin
            dp_pend = 1;
            dp_cnt  = DP_L - 1;
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (bus.read_again) n_ra++;
         if (bus.dp_start) begin
            n_ds++;
            ds_cyc = cyc;
         end
         if (bus.result_mem_we) begin
            n_we++;
            wr_addr.push_back(bus.result_addr);
            wr_data.push_back(bus.result_data);
            wr_mask.push_back(bus.lane_mask);
            wr_cyc.push_back(cyc);
         end
      end
   end

   task automatic pulse_start(input logic [31:0] t, input logic o, input logic [63:0] c);
      @(posedge clk);
      #2;
      bus.total    = t;
      bus.op       = o;
      bus.constant = c;
      bus.start    = 1'b1;
      @(posedge clk);
      #2;
      bus.start = 1'b0;
   endtask

   task automatic wait_finish(input int maxc);
      int w;
      w = 0;
      while (!bus.finish && w < maxc) begin
         @(negedge clk);
         w++;
      end
      #1;
   endtask

   task automatic check_zero(input string tag);
      chk($sformatf("%s_flags", tag),
          {bus.busy, bus.finish, bus.error, bus.read_again, bus.dp_start, bus.result_mem_we, bus.dp_op}, 7'b0);
      chk($sformatf("%s_rd_addr", tag), bus.rd_addr, 16'd0);
      chk($sformatf("%s_res_addr", tag), bus.result_addr, 16'd0);
      chk($sformatf("%s_mask", tag), bus.lane_mask, 8'd0);
      chk($sformatf("%s_res_data", tag), bus.result_data, 512'd0);
      chk($sformatf("%s_rows", tag), bus.dp_first_row | bus.dp_second_row, 512'd0);
      chk($sformatf("%s_const", tag), bus.dp_constant, 64'd0);
   endtask

   task automatic check_blocks(input string tag, input int base, input int nb, input int tot,
                               input logic [63:0] c, input logic op);
      logic [7:0] m;
      chk($sformatf("%s_nwr", tag), wr_addr.size() - base, nb);
      for (int b = 0; b < nb; b++) begin
         if (base + b < wr_addr.size()) begin
            m = 8'hFF;
            if (b == nb - 1 && tot % NI != 0)
               m = 8'((1 << (tot % NI)) - 1);
            chk($sformatf("%s_addr%0d", tag, b), wr_addr[base+b], 16'(b));
            chk($sformatf("%s_data%0d", tag, b), wr_data[base+b], dp_f(row_a(b), row_b(b), c, op));
            chk($sformatf("%s_mask%0d", tag, b), wr_mask[base+b], m);
         end
      end
   endtask

   initial begin
      int base, ra0, ds0, we0, err_cyc, w;

      bus.start    = 1'b0;
      bus.total    = '0;
      bus.op       = 1'b0;
      bus.constant = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check_zero("rst");
      @(posedge clk);
      #2 reset = 1'b0;

      // total=16, 1-cycle read, L=3: two full blocks, writes 7 cycles apart
      base = wr_addr.size();
      ra0 = n_ra; ds0 = n_ds;
      pulse_start(32'd16, 1'b0, 64'h0000_0100_0000_0200);
      wait_finish(200);
      chk("t16_finish", bus.finish, 1'b1);
      chk("t16_err_busy", {bus.error, bus.busy}, 2'b00);
      check_blocks("t16", base, 2, 16, 64'h0000_0100_0000_0200, 1'b0);
      chk("t16_nrd", n_ra - ra0, 2);
      chk("t16_nissue", n_ds - ds0, 2);
      if (wr_cyc.size() >= base + 2) begin
         chk("t16_wr_gap", wr_cyc[base+1] - wr_cyc[base], DP_L + 4);
         chk("t16_fin_lat", cyc - wr_cyc[base+1], 1);
      end

      // total=13: partial tail block, op=1
      base = wr_addr.size();
      pulse_start(32'd13, 1'b1, 64'hFFFF_FFF0_0000_0033);
      wait_finish(200);
      chk("t13_finish", bus.finish, 1'b1);
      check_blocks("t13", base, 2, 13, 64'hFFFF_FFF0_0000_0033, 1'b1);

      // Stray dp_done in WAIT_RD and a start during WAIT_DP are both ignored
      base = wr_addr.size();
      ra0 = n_ra; ds0 = n_ds; we0 = n_we;
      rd_dly = 3;
      pulse_start(32'd8, 1'b0, 64'h0000_0007_0000_0009);
      @(posedge clk); #2;
      @(posedge clk); #2 stray_dp = 1'b1;
      @(posedge clk); #2 stray_dp = 1'b0;
      chk("stray_busy", bus.busy, 1'b1);
      @(posedge clk); #2;
      @(posedge clk); #2;
      @(posedge clk); #2;
      bus.total = 32'd64;
      bus.start = 1'b1;
      @(posedge clk); #2;
      bus.start = 1'b0;
      wait_finish(200);
      rd_dly = 0;
      chk("stray_finish", bus.finish, 1'b1);
      chk("stray_nrd", n_ra - ra0, 1);
      chk("stray_nissue", n_ds - ds0, 1);
      chk("stray_nwr", n_we - we0, 1);
      check_blocks("stray", base, 1, 8, 64'h0000_0007_0000_0009, 1'b0);

      // dp_done withheld: abort after TIMEOUT cycles of WAIT_DP, no write
      we0 = n_we;
      dp_en = 1'b0;
      pulse_start(32'd8, 1'b0, 64'd1);
      w = 0;
      while (!bus.error && w < 100) begin
         @(negedge clk);
         w++;
      end
      err_cyc = cyc;
      dp_en = 1'b1;
      chk("tmo_error", bus.error, 1'b1);
      chk("tmo_finish_busy", {bus.finish, bus.busy}, 2'b10);
      chk("tmo_latency", err_cyc - ds_cyc, TMO + 1);
      chk("tmo_nwr", n_we - we0, 0);

      // total=0: finish the next cycle, error cleared, no strobes
      ra0 = n_ra; ds0 = n_ds; we0 = n_we;
      pulse_start(32'd0, 1'b0, 64'd5);
      @(negedge clk);
      chk("t0_flags", {bus.finish, bus.error, bus.busy}, 3'b100);
      repeat (4) @(negedge clk);
      #1;
      chk("t0_strobes", (n_ra - ra0) + (n_ds - ds0) + (n_we - we0), 0);

      // Reset in WAIT_DP of block 1 of 4, then a clean job from block 0
      ds0 = n_ds; we0 = n_we;
      pulse_start(32'd32, 1'b1, 64'h1111_2222_3333_4444);
      w = 0;
      while (n_ds < ds0 + 2 && w < 100) begin
         @(posedge clk);
         #1;
         w++;
      end
      chk("mid_reached_blk1", n_ds - ds0, 2);
      #1 reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_zero("mid_rst");
      repeat (3) @(negedge clk);
      chk("mid_nwr", n_we - we0, 1);
      @(posedge clk);
      #2 reset = 1'b0;
      base = wr_addr.size();
      pulse_start(32'd16, 1'b0, 64'h0000_00AA_0000_00BB);
      wait_finish(200);
      chk("restart_finish", bus.finish, 1'b1);
      check_blocks("restart", base, 2, 16, 64'h0000_00AA_0000_00BB, 1'b0);

      // Random read latency 0-5 cycles over five blocks
      base = wr_addr.size();
      rd_rand = 1'b1;
      pulse_start(32'd40, 1'b1, 64'h0BAD_F00D_0000_1234);
      wait_finish(400);
      rd_rand = 1'b0;
      chk("rand_finish", {bus.finish, bus.error}, 2'b10);
      check_blocks("rand", base, 5, 40, 64'h0BAD_F00D_0000_1234, 1'b1);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
